// File: rtl/envelope_generator_adsr_pkg.sv
// Shared types and constants for the ADSR envelope generator and its scaler.
package synth_pkg;

  localparam int ENV_LEVEL_W  = 16;
  localparam int ENV_SAMPLE_W = 16;
  localparam logic [ENV_LEVEL_W-1:0] LEVEL_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/envelope_generator_adsr_scale.sv
// Registered signed-sample x unsigned-level multiply; keeps the top 16 bits of the fraction product.
module env_scale
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = ENV_SAMPLE_W,
  parameter int LEVEL_W  = ENV_LEVEL_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [LEVEL_W-1:0]  level_i,
  output logic [SAMPLE_W-1:0] out_o,
  output logic                valid_o
);

  logic signed [SAMPLE_W+LEVEL_W:0] prod;
  logic [SAMPLE_W-1:0] out_d, out_q;
  logic                valid_q;
  logic                prod_unused;

  // Level is zero-extended so it multiplies as a non-negative fraction.
  assign prod        = $signed(sample_i) * $signed({1'b0, level_i});
  assign out_d       = prod[SAMPLE_W+LEVEL_W-1 -: SAMPLE_W];
  assign prod_unused = ^{prod[SAMPLE_W+LEVEL_W], prod[LEVEL_W-1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= tick_i;
      if (tick_i) out_q <= out_d;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/envelope_generator_adsr.sv
// Per-voice ADSR envelope: gate edge detection, level state machine and output scaling.
// Handshake: out_valid is a one-Clk pulse following each sample_Clk tick; there is no backpressure.
module envelope_generator_adsr
  import synth_pkg::*;
#(
  parameter int LEVEL_W  = ENV_LEVEL_W,
  parameter int SAMPLE_W = ENV_SAMPLE_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                sample_Clk,
  input  logic                gate,
  input  logic [LEVEL_W-1:0]  attack_step,
  input  logic [LEVEL_W-1:0]  decay_step,
  input  logic [LEVEL_W-1:0]  sustain_level,
  input  logic [LEVEL_W-1:0]  release_step,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] out,
  output logic                out_valid,
  output logic [LEVEL_W-1:0]  env_level,
  output logic                active,
  output logic [2:0]          env_state
);

  env_state_t state_q, state_d, mode;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               gate_q, gate_d;
  logic               rise, fall;
  logic [LEVEL_W:0]   att_sum, dec_diff, rel_diff;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= gate_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    gate_d   = gate_q;
    rise     = gate & ~gate_q;
    fall     = ~gate & gate_q;
    att_sum  = {1'b0, level_q} + {1'b0, attack_step};
    dec_diff = {1'b0, level_q} - {1'b0, decay_step};
    rel_diff = {1'b0, level_q} - {1'b0, release_step};

    // A gate edge picks the state whose arithmetic runs on this same tick.
    mode = state_q;
    if (fall && (state_q inside {ATTACK, DECAY, SUSTAIN})) mode = RELEASE;
    else if (rise)                                         mode = ATTACK;

    if (sample_Clk) begin
      gate_d = gate;
      case (mode)
        ATTACK: begin
          if (attack_step == '0 || att_sum[LEVEL_W] || att_sum[LEVEL_W-1:0] == LEVEL_MAX) begin
            level_d = LEVEL_MAX;
            state_d = DECAY;
          end else begin
            level_d = att_sum[LEVEL_W-1:0];
            state_d = ATTACK;
          end
        end
        DECAY: begin
          if (decay_step == '0 || dec_diff[LEVEL_W] || dec_diff[LEVEL_W-1:0] <= sustain_level) begin
            level_d = sustain_level;
            state_d = SUSTAIN;
          end else begin
            level_d = dec_diff[LEVEL_W-1:0];
            state_d = DECAY;
          end
        end
        SUSTAIN: begin
          level_d = sustain_level;
          state_d = SUSTAIN;
        end
        RELEASE: begin
          if (release_step == '0 || rel_diff[LEVEL_W] || rel_diff[LEVEL_W-1:0] == '0) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = rel_diff[LEVEL_W-1:0];
            state_d = RELEASE;
          end
        end
        default: begin
          level_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Scaling uses the level held before this tick's update.
  env_scale #(
    .SAMPLE_W (SAMPLE_W),
    .LEVEL_W  (LEVEL_W)
  ) u_scale (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .tick_i   (sample_Clk),
    .sample_i (sample_in),
    .level_i  (level_q),
    .out_o    (out),
    .valid_o  (out_valid)
  );

  assign env_level = level_q;
  assign active    = (state_q != IDLE);
  assign env_state = state_q;

endmodule

// File: tb/tb_envelope_generator_adsr.sv
// Directed bench for envelope_generator_adsr with hand-computed levels, states and scaled outputs.
module tb_envelope_generator_adsr;
  import synth_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        sample_Clk;
  logic        gate;
  logic [15:0] attack_step, decay_step, sustain_level, release_step;
  logic [15:0] sample_in;
  logic [15:0] out;
  logic        out_valid;
  logic [15:0] env_level;
  logic        active;
  logic [2:0]  env_state;

  int n_checks = 0;
  int n_errors = 0;

  envelope_generator_adsr dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .sample_Clk    (sample_Clk),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .sample_in     (sample_in),
    .out           (out),
    .out_valid     (out_valid),
    .env_level     (env_level),
    .active        (active),
    .env_state     (env_state)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One-Clk tick; returns at the negedge after the capturing edge.
  task automatic tick;
    @(negedge Clk);
    sample_Clk = 1'b1;
    @(negedge Clk);
    sample_Clk = 1'b0;
  endtask

  task automatic step_chk(input string tag, input logic [15:0] lvl, input logic [2:0] st);
    idle(2);
    tick();
    check({tag, " level"}, {16'h0, env_level}, {16'h0, lvl});
    check({tag, " state"}, {29'h0, env_state}, {29'h0, st});
    check({tag, " active"}, {31'h0, active}, {31'h0, (st != 3'd0)});
    check({tag, " valid"}, {31'h0, out_valid}, 32'h1);
    @(negedge Clk);
    check({tag, " valid_off"}, {31'h0, out_valid}, 32'h0);
  endtask

  logic [15:0] t1_lvl [9] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hEFFF,
                              16'hDFFF, 16'hCFFF, 16'hC000, 16'hC000};
  logic [2:0]  t1_st  [9] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3};

  initial begin
    Reset = 1'b1; sample_Clk = 1'b0; gate = 1'b0;
    attack_step = '0; decay_step = '0; sustain_level = '0; release_step = '0;
    sample_in = '0;
    #12;
    check("rst level", {16'h0, env_level}, 32'h0);
    check("rst state", {29'h0, env_state}, 32'h0);
    check("rst out", {16'h0, out}, 32'h0);
    check("rst valid", {31'h0, out_valid}, 32'h0);
    check("rst active", {31'h0, active}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    // Attack, decay, sustain
    attack_step = 16'h4000; decay_step = 16'h1000; sustain_level = 16'hC000; release_step = 16'h5000;
    gate = 1'b1;
    for (int i = 0; i < 9; i++) step_chk($sformatf("ads%0d", i), t1_lvl[i], t1_st[i]);

    // Release to idle
    gate = 1'b0;
    step_chk("rel0", 16'h7000, 3'd4);
    step_chk("rel1", 16'h2000, 3'd4);
    step_chk("rel2", 16'h0000, 3'd0);

    // Zero steps and live sustain
    attack_step = 16'h0; decay_step = 16'h0; sustain_level = 16'h2000;
    gate = 1'b1;
    step_chk("zs_att", 16'hFFFF, 3'd2);
    step_chk("zs_dec", 16'h2000, 3'd3);
    sustain_level = 16'h3000;
    step_chk("zs_live", 16'h3000, 3'd3);

    // Retrigger from release
    sustain_level = 16'hC000;
    step_chk("rt_sus", 16'hC000, 3'd3);
    gate = 1'b0;
    step_chk("rt_rel", 16'h7000, 3'd4);
    attack_step = 16'h4000; gate = 1'b1;
    step_chk("rt_a0", 16'hB000, 3'd1);
    step_chk("rt_a1", 16'hF000, 3'd1);
    step_chk("rt_a2", 16'hFFFF, 3'd2);

    // Scaling at level 0x8000
    sustain_level = 16'h8000;
    step_chk("sc_sus", 16'h8000, 3'd3);
    sample_in = 16'h7FFF;
    step_chk("sc_pos", 16'h8000, 3'd3);
    check("sc_pos out", {16'h0, out}, 32'h3FFF);
    idle(2);
    check("sc_hold out", {16'h0, out}, 32'h3FFF);
    sample_in = 16'h8000;
    step_chk("sc_neg", 16'h8000, 3'd3);
    check("sc_neg out", {16'h0, out}, 32'hC000);
    sample_in = 16'h1234;
    step_chk("sc_mid", 16'h8000, 3'd3);
    check("sc_mid out", {16'h0, out}, 32'h091A);

    // Async reset mid-attack
    gate = 1'b0; release_step = 16'h0;
    step_chk("ar_idle", 16'h0000, 3'd0);
    sample_in = 16'h7FFF; gate = 1'b1;
    step_chk("ar_a0", 16'h4000, 3'd1);
    check("ar_a0 out", {16'h0, out}, 32'h0);
    idle(2);
    tick();
    check("ar_a1 level", {16'h0, env_level}, 32'h8000);
    check("ar_a1 out", {16'h0, out}, 32'h1FFF);
    #2 Reset = 1'b1;
    #1;
    check("ar level", {16'h0, env_level}, 32'h0);
    check("ar out", {16'h0, out}, 32'h0);
    check("ar valid", {31'h0, out_valid}, 32'h0);
    check("ar state", {29'h0, env_state}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    step_chk("ar_rise", 16'h4000, 3'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
